// File: rtl/f11_dma_arb.sv
// f11_dma_arb: Q-bus DMR/DMG/SACK bus-mastership arbiter.
// Stalls the CPU while an external master owns the bus; withdraws a grant nobody acknowledges.
module f11_dma_arb #(
    parameter int SACK_TMO = 255,
    parameter int HOLDOFF  = 4
) (
    input  logic pin_clk,
    input  logic pin_rst,
    input  logic pin_dmr_n,
    input  logic pin_sack_n,
    input  logic pin_sync_n,
    output logic pin_dmg_n,
    input  logic cpu_busy,
    output logic cpu_hold,
    output logic dma_act,
    output logic tmo_err
);
    localparam int CW = ($clog2(SACK_TMO + 1) > 8) ? $clog2(SACK_TMO + 1) : 8;

    typedef enum logic [2:0] {IDLE, WAIT_CPU, GRANT, DMA, RELEASE, HOLD} state_t;

    state_t        state_q, state_d;
    logic [1:0]    dmr_q, sack_q, sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dmg_n_q, dmg_n_d, hold_q, hold_d, act_q, act_d, tmo_q, tmo_d;
    logic          dmr, sack, bsync;

    assign dmr   = dmr_q[1];
    assign sack  = sack_q[1];
    assign bsync = sync_q[1];

    always_ff @(posedge pin_clk or posedge pin_rst) begin
        if (pin_rst) begin
            state_q <= IDLE;
            dmr_q   <= '0;
            sack_q  <= '0;
            sync_q  <= '0;
            cnt_q   <= '0;
            dmg_n_q <= 1'b1;
            hold_q  <= 1'b0;
            act_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dmr_q   <= {dmr_q[0], ~pin_dmr_n};
            sack_q  <= {sack_q[0], ~pin_sack_n};
            sync_q  <= {sync_q[0], ~pin_sync_n};
            cnt_q   <= cnt_d;
            dmg_n_q <= dmg_n_d;
            hold_q  <= hold_d;
            act_q   <= act_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
        tmo_d   = 1'b0;
        case (state_q)
            IDLE:     if (dmr) state_d = WAIT_CPU;
            WAIT_CPU: if (!dmr) state_d = IDLE;
                      else if (!cpu_busy && !bsync) begin
                          state_d = GRANT;
                          cnt_d   = CW'(SACK_TMO);
                      end
            GRANT:    if (sack) state_d = DMA;
                      else if (!dmr) state_d = IDLE;
                      else if (cnt_q == '0) begin
                          state_d = HOLD;
                          cnt_d   = CW'(HOLDOFF);
                          tmo_d   = 1'b1;
                      end
            DMA:      if (!sack) state_d = RELEASE;
            RELEASE:  if (!bsync) begin
                          state_d = HOLD;
                          cnt_d   = CW'(HOLDOFF);
                      end
            HOLD:     if (cnt_q == '0) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        dmg_n_d = state_d != GRANT;
        hold_d  = state_d inside {WAIT_CPU, GRANT, DMA, RELEASE};
        act_d   = state_d == DMA;
    end

    // Stray SACK outside a grant stalls the CPU while it persists
    assign cpu_hold  = hold_q | sack;
    assign pin_dmg_n = dmg_n_q;
    assign dma_act   = act_q;
    assign tmo_err   = tmo_q;
endmodule

// File: tb/tb_f11_dma_arb.sv
// tb_f11_dma_arb: scoreboard bench; expected output-change events (cycle, value) are queued by stimulus.
module tb_f11_dma_arb;
    logic clk = 1'b0, rst = 1'b1, dmr_n = 1'b1, sack_n = 1'b1, sync_n = 1'b1, busy = 1'b0;
    logic dmg_n, hold, act, tmo;
    logic [3:0] vec, prev;
    int cyc = 0, n_cmp = 0, n_err = 0, c0 = 0;
    bit mon_on = 1'b0;

    typedef struct {int c; logic [3:0] v;} ev_t;
    ev_t q[$];

    f11_dma_arb #(.SACK_TMO(15), .HOLDOFF(4)) dut (
        .pin_clk(clk), .pin_rst(rst), .pin_dmr_n(dmr_n), .pin_sack_n(sack_n),
        .pin_sync_n(sync_n), .pin_dmg_n(dmg_n), .cpu_busy(busy), .cpu_hold(hold),
        .dma_act(act), .tmo_err(tmo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign vec = {dmg_n, hold, act, tmo};

    task automatic exp_ev(input int dc, input logic [3:0] v);
        ev_t e;
        e.c = c0 + dc;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // vec = {pin_dmg_n, cpu_hold, dma_act, tmo_err}
    always begin
        ev_t e;
        @(vec);
        #1;
        if (mon_on && vec !== prev) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event cyc=%0d got=%b required=none", cyc, vec);
            end else begin
                e = q.pop_front();
                if (e.c != cyc || e.v !== vec) begin
                    n_err++;
                    $display("FAIL event got cyc=%0d vec=%b required cyc=%0d vec=%b", cyc, vec, e.c, e.v);
                end
            end
            prev = vec;
        end
    end

    initial begin
        tick(3);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (vec !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_state got=%b required=1000", vec);
        end
        prev   = vec;
        mon_on = 1'b1;
        tick(2);
        // basic handshake
        c0 = cyc; dmr_n = 1'b0;
        exp_ev(3, 4'b1100); exp_ev(4, 4'b0100);
        tick(6); sack_n = 1'b0; sync_n = 1'b0; exp_ev(9, 4'b1110);
        tick(6); sack_n = 1'b1; dmr_n = 1'b1; exp_ev(15, 4'b1100);
        tick(6); sync_n = 1'b1; exp_ev(21, 4'b1000);
        tick(12);
        // CPU cycle in flight, then request withdrawn during grant
        c0 = cyc; busy = 1'b1; dmr_n = 1'b0; exp_ev(3, 4'b1100);
        tick(10); busy = 1'b0; exp_ev(11, 4'b0100);
        tick(3); dmr_n = 1'b1; exp_ev(16, 4'b1000);
        tick(8);
        // SACK timeout, holdoff, re-grant
        c0 = cyc; dmr_n = 1'b0;
        exp_ev(3, 4'b1100); exp_ev(4, 4'b0100); exp_ev(20, 4'b1001);
        exp_ev(21, 4'b1000); exp_ev(26, 4'b1100); exp_ev(27, 4'b0100);
        tick(28); dmr_n = 1'b1; exp_ev(31, 4'b1000);
        tick(8);
        // reset mid-DMA
        c0 = cyc; dmr_n = 1'b0;
        exp_ev(3, 4'b1100); exp_ev(4, 4'b0100);
        tick(5); sack_n = 1'b0; sync_n = 1'b0; exp_ev(8, 4'b1110);
        tick(5); #2;
        exp_ev(10, 4'b1000);
        sack_n = 1'b1; sync_n = 1'b1; rst = 1'b1;
        #1;
        n_cmp++;
        if (vec !== 4'b1000) begin
            n_err++;
            $display("FAIL async_reset got=%b required=1000", vec);
        end
        tick(1); rst = 1'b0; c0 = cyc;
        exp_ev(3, 4'b1100); exp_ev(4, 4'b0100);
        tick(5); dmr_n = 1'b1; c0 = cyc; exp_ev(3, 4'b1000);
        tick(8);
        // stray SACK in IDLE
        c0 = cyc; sack_n = 1'b0; exp_ev(2, 4'b1100);
        tick(8); sack_n = 1'b1; exp_ev(10, 4'b1000);
        tick(8);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL pending_events got=%0d required=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/f11_dma_arb.md
# f11_dma_arb

Q-bus DMA bus-mastership arbiter for the F-11 board wrapper. It sits beside the CPU bus-cycle logic and sequences the Q-bus DMR/DMG/SACK handshake. It stalls new CPU bus cycles while an external master owns the bus, and recovers from a grant that no device acknowledges.

## Interface
- `SACK_TMO`, default 255: clocks DMG may stay asserted without SACK before the grant is withdrawn (range 1..65535).
- `HOLDOFF`, default 4: clocks after a DMA release or timeout during which DMR is ignored, so the CPU gets bus access (range 1..255).

Ports:
- `pin_clk`  in  1  processor clock; all state changes on its rising edge.
- `pin_rst`  in  1  asynchronous active-high reset.
- `pin_dmr_n`  in  1  Q-bus DMA request, active low, asynchronous.
- `pin_sack_n`  in  1  Q-bus select acknowledge, active low, asynchronous.
- `pin_sync_n`  in  1  Q-bus SYNC monitor, active low, asynchronous.
- `pin_dmg_n`  out  1  Q-bus DMA grant, active low, registered.
- `cpu_busy`  in  1  CPU bus cycle in progress, from CPU SYNC/DIN/DOUT logic; already synchronous.
- `cpu_hold`  out  1  CPU must not start a new bus cycle; registered.
- `dma_act`  out  1  external master owns the bus (SACK accepted).
- `tmo_err`  out  1  one-clock pulse when a grant times out.

## Operation
- **Input synchronisation.** DMR, SACK and SYNC pass through 2-flop synchronisers, giving internal `dmr`, `sack`, `bsync` (active high). Decisions use only the synchronised values.
- **IDLE**
  - Outputs: `cpu_hold=0`, `pin_dmg_n=1`.
  - `dmr=1` -> WAIT_CPU.
- **WAIT_CPU**
  - `cpu_hold=1`. A CPU cycle already in progress runs to completion.
  - `dmr=0` -> IDLE (request withdrawn).
  - `cpu_busy=0` and `bsync=0` -> GRANT; load the timeout counter with `SACK_TMO`.
- **GRANT**
  - Outputs: `cpu_hold=1`, `pin_dmg_n=0`. The counter decrements each clock.
  - `sack=1` -> DMA.
  - Otherwise `dmr=0` -> IDLE.
  - Otherwise counter==0 -> HOLD; pulse `tmo_err`.
  - Priority: sack > dmr withdrawn > timeout.
- **DMA**
  - Outputs: `cpu_hold=1`, `pin_dmg_n=1` (grant removed once SACK is seen), `dma_act=1`.
  - `sack=0` -> RELEASE.
- **RELEASE**
  - Outputs: `cpu_hold=1`, `dma_act=0`.
  - `bsync=0` (the master's last cycle has ended) -> HOLD; load the holdoff counter with `HOLDOFF`.
- **HOLD**
  - Outputs: `cpu_hold=0`, `pin_dmg_n=1`. DMR is ignored. The counter decrements each clock.
  - Counter==0 -> IDLE.
  - The timeout path also loads `HOLDOFF` on entry.
- **SACK outside GRANT/DMA.** Asserted while in IDLE/WAIT_CPU/HOLD, it forces `cpu_hold=1` for as long as it is present, as a protocol guard. No state change occurs.
- **Reset.**
  - State goes to IDLE; counters and synchronisers clear.
  - Reset values: `pin_dmg_n=1`, `cpu_hold=0`, `dma_act=0`, `tmo_err=0`.
  - Reset mid-grant drops DMG asynchronously.
- **Counters.** Width is `$clog2(SACK_TMO+1)` (at least 8 bits), shared by timeout and holdoff. No wrap: the counter stops at 0.

## Timing
- DMR pin falling edge to `cpu_hold=1`: 3–4 clocks (2 synchroniser stages + 1 state register, plus phase uncertainty).
- WAIT_CPU to GRANT: 1 clock after both `cpu_busy=0` and `bsync=0` are sampled. `pin_dmg_n` falls on the same edge that enters GRANT.
- SACK pin low to `pin_dmg_n=1`: 3 clocks.
- Timeout: `pin_dmg_n` is low for exactly `SACK_TMO+1` clocks. `tmo_err` is high on the clock that enters HOLD.
- In DMA/RELEASE, `cpu_hold` deasserts only on entry to HOLD, which is at least 1 clock after `bsync=0`.
- All outputs are registered with no combinational pin-to-pin path. The `cpu_hold` SACK-guard term is ORed from the registered `sack`.

## Test plan
- **Basic handshake.** DMR low with CPU idle -> DMG low 3–4 clocks later. SACK low -> DMG high 3 clocks later and `dma_act=1`. Release SACK and SYNC -> `cpu_hold` low after RELEASE plus 4 HOLD clocks.
- **CPU cycle in flight.** `cpu_busy=1` for 10 clocks when DMR arrives -> `cpu_hold=1` immediately. DMG stays high until 1 clock after `cpu_busy` falls.
- **Timeout.** `SACK_TMO=15`; DMR held, SACK never returned -> DMG low for 16 clocks, then one `tmo_err` pulse. DMR is ignored for 4 clocks, then a new grant is issued.
- **Withdrawn request.** DMR released 2 clocks after DMG asserts -> DMG high next clock (after sync delay), state IDLE, no `tmo_err`.
- **Reset mid-DMA.** `pin_rst` pulsed while `dma_act=1` -> `pin_dmg_n=1`, `cpu_hold=0`, `dma_act=0` without a clock edge. With DMR still low, normal re-arbitration follows.
- **Stray SACK.** SACK low in IDLE with DMR high -> `cpu_hold=1` while SACK is low, DMG never asserted.
